// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two refill requesters, the arbiter and memory.
// master: arbiter side; slave: requesters plus the memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              done0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              done1;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;

  modport master (
    input  req0, addr0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata, mem_ack,
    output gnt0, ack0, rdata0, done0,
    output gnt1, ack1, rdata1, done1,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, busy
  );

  modport slave (
    output req0, addr0,
    output req1, we1, addr1, wdata1,
    output mem_rdata, mem_ack,
    input  gnt0, ack0, rdata0, done0,
    input  gnt1, ack1, rdata1, done1,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter + block burst sequencer for the shared memory port.
// Ports: clk, reset (async, active-low), bus (mem_port_arbiter_if.master).
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int BW  = $clog2(BURST_LEN);
  localparam int OFS = BW + 2;
  localparam logic [ADDR_W-1:0] LOW =
    (ADDR_W'(1) << OFS) - ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;

  logic gnt0_q, gnt0_d;
  logic gnt1_q, gnt1_d;
  logic done0_q, done0_d;
  logic done1_q, done1_d;
  logic mreq_q, mreq_d;
  logic mwe_q, mwe_d;
  logic busy_q, busy_d;

  logic in_burst;
  logic beat_ack;
  logic last_beat;
  logic pick;

  always_comb begin
    in_burst  = (state_q == BURST);
    beat_ack  = in_burst & bus.mem_ack;
    last_beat = (beat_q == BW'(BURST_LEN - 1));
    // on a tie, port 1 wins unless it was granted last
    pick      = bus.req1 & (~bus.req0 | ~last_q);

    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    last_d  = last_q;
    base_d  = base_q;
    beat_d  = beat_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          port_d  = pick;
          base_d  = (pick ? bus.addr1 : bus.addr0) & ~LOW;
          we_d    = pick & bus.we1;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat_ack) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        last_d  = port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt0_d  = (state_d != IDLE) & ~port_d;
    gnt1_d  = (state_d != IDLE) & port_d;
    done0_d = (state_d == DONE) & ~port_d;
    done1_d = (state_d == DONE) & port_d;
    mreq_d  = (state_d == BURST);
    mwe_d   = (state_d == BURST) & we_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      last_q  <= last_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      busy_q  <= busy_d;
    end
  end

  // beat acks and read data pass straight through to the owner
  assign bus.ack0   = beat_ack & ~port_q;
  assign bus.ack1   = beat_ack & port_q;
  assign bus.rdata0 = bus.ack0 ? bus.mem_rdata : '0;
  assign bus.rdata1 = bus.ack1 ? bus.mem_rdata : '0;

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.mem_req = mreq_q;
  assign bus.mem_we  = mwe_q;
  assign bus.busy    = busy_q;

  assign bus.mem_addr = in_burst ?
    base_q + ADDR_W'({beat_q, 2'b00}) : '0;
  assign bus.mem_wdata = (in_burst & port_q & we_q) ?
    bus.wdata1 : '0;

endmodule
